// File: rtl/fp8_lb_pkg.sv
// Shared types and defaults for the FP8 line-buffer RAM controller.
package fp8_lb_pkg;

  localparam int unsigned LineWidthDef = 640;
  localparam int unsigned AddrBitsDef  = 10;

  localparam logic [7:0] FP8_ZERO = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StRdOld,
    StRdNew,
    StWr
  } state_e;

  // Completed-line count saturates at two: beyond that both banks stay valid.
  function automatic logic [1:0] lines_inc(input logic [1:0] n);
    return (n == 2'd2) ? 2'd2 : n + 2'd1;
  endfunction

endpackage

// File: rtl/fp8_line_ram_ctrl_if.sv
// Pixel/data handshake between a line_buffer_unit (master) and the RAM controller (slave).
interface fp8_line_ram_ctrl_if #(
  parameter int unsigned AddrBits = 10
);

  logic                sof;
  logic                wr_src;
  logic                pix_valid;
  logic                pix_ready;
  logic [7:0]          wr_data;
  logic                sel;
  logic [7:0]          rd_data;
  logic                rd_stb;
  logic                window_valid;
  logic [AddrBits-1:0] col;

  modport master (
    output sof, wr_src, pix_valid, wr_data,
    input  pix_ready, sel, rd_data, rd_stb, window_valid, col
  );

  modport slave (
    input  sof, wr_src, pix_valid, wr_data,
    output pix_ready, sel, rd_data, rd_stb, window_valid, col
  );

endinterface

// File: rtl/fp8_bank_ram.sv
// Single-port synchronous RAM holding both line banks; read-first, registered read data.
module fp8_bank_ram #(
  parameter int unsigned AddrBits = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AddrBits:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  localparam int unsigned Depth = 2 ** (AddrBits + 1);

  logic [7:0] mem_q [Depth];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fp8_line_ram_ctrl.sv
// FP8 line-buffer RAM controller: per pixel reads the older row, the newer row, then
// writes the current row, with fill masking and start-of-frame handling.
module fp8_line_ram_ctrl
  import fp8_lb_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = LineWidthDef,
  parameter int unsigned ADDR_BITS  = AddrBitsDef
) (
  input  logic                      clk,
  input  logic                      reset,
  fp8_line_ram_ctrl_if.slave        bus
);

  localparam logic [ADDR_BITS-1:0] ColLast = ADDR_BITS'(LINE_WIDTH - 1);
  localparam logic [ADDR_BITS-1:0] ColOne  = ADDR_BITS'(1);

  state_e               st_q, st_d;
  logic [ADDR_BITS-1:0] col_q, col_d;
  logic                 old_bank_q, old_bank_d;
  logic [1:0]           lines_q, lines_d;
  logic                 pend_sof_q, pend_sof_d;
  logic                 pend_src_q, pend_src_d;
  logic                 sel_q, sel_d;
  logic                 mask_q, mask_d;
  logic                 rd_stb_q, rd_stb_d;
  logic                 pix_ready_q, pix_ready_d;
  logic                 win_q, win_d;
  logic [7:0]           hold_q;

  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_BITS:0]   ram_addr;
  logic [7:0]           ram_rdata;
  logic [7:0]           rd_byte;
  logic [7:0]           rd_data;

  always_comb begin
    st_d       = st_q;
    col_d      = col_q;
    old_bank_d = old_bank_q;
    lines_d    = lines_q;
    pend_sof_d = pend_sof_q;
    pend_src_d = pend_src_q;
    sel_d      = sel_q;
    mask_d     = mask_q;
    case (st_q)
      StIdle: begin
        if (bus.pix_valid) st_d = StRdOld;
        if (bus.sof) begin
          col_d      = '0;
          old_bank_d = 1'b0;
          lines_d    = 2'd0;
          sel_d      = bus.wr_src;
        end
      end
      StRdOld: begin
        st_d   = StRdNew;
        mask_d = (lines_q == 2'd2);
      end
      StRdNew: begin
        st_d   = StWr;
        mask_d = (lines_q != 2'd0);
      end
      StWr: begin
        st_d = bus.pix_valid ? StRdOld : StIdle;
        // A frame restart takes priority over the column increment and any wrap.
        if (bus.sof || pend_sof_q) begin
          col_d      = '0;
          old_bank_d = 1'b0;
          lines_d    = 2'd0;
          sel_d      = bus.sof ? bus.wr_src : pend_src_q;
          pend_sof_d = 1'b0;
        end else if (col_q == ColLast) begin
          col_d      = '0;
          old_bank_d = ~old_bank_q;
          lines_d    = lines_inc(lines_q);
        end else begin
          col_d = col_q + ColOne;
        end
      end
      default: st_d = StIdle;
    endcase
    if (bus.sof && (st_q == StRdOld || st_q == StRdNew)) begin
      pend_sof_d = 1'b1;
      pend_src_d = bus.wr_src;
    end
  end

  assign rd_stb_d    = (st_d == StRdNew) || (st_d == StWr);
  assign pix_ready_d = (st_d == StWr);
  assign win_d       = (lines_d == 2'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= StIdle;
      col_q       <= '0;
      old_bank_q  <= 1'b0;
      lines_q     <= 2'd0;
      pend_sof_q  <= 1'b0;
      pend_src_q  <= 1'b0;
      sel_q       <= 1'b0;
      mask_q      <= 1'b0;
      rd_stb_q    <= 1'b0;
      pix_ready_q <= 1'b0;
      win_q       <= 1'b0;
      hold_q      <= FP8_ZERO;
    end else begin
      st_q        <= st_d;
      col_q       <= col_d;
      old_bank_q  <= old_bank_d;
      lines_q     <= lines_d;
      pend_sof_q  <= pend_sof_d;
      pend_src_q  <= pend_src_d;
      sel_q       <= sel_d;
      mask_q      <= mask_d;
      rd_stb_q    <= rd_stb_d;
      pix_ready_q <= pix_ready_d;
      win_q       <= win_d;
      hold_q      <= rd_data;
    end
  end

  // The write in WR lands after the RD_OLD read of the same address.
  always_comb begin
    ram_en   = (st_q != StIdle);
    ram_we   = (st_q == StWr);
    ram_addr = (st_q == StRdNew) ? {~old_bank_q, col_q} : {old_bank_q, col_q};
  end

  fp8_bank_ram #(
    .AddrBits (ADDR_BITS)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (bus.wr_data),
    .rdata_o (ram_rdata)
  );

  assign rd_byte = mask_q ? ram_rdata : FP8_ZERO;
  assign rd_data = rd_stb_q ? rd_byte : hold_q;

  assign bus.rd_data      = rd_data;
  assign bus.rd_stb       = rd_stb_q;
  assign bus.pix_ready    = pix_ready_q;
  assign bus.sel          = sel_q;
  assign bus.window_valid = win_q;
  assign bus.col          = col_q;

endmodule

// File: tb/tb_fp8_line_ram_ctrl.sv
// Directed, table-driven bench for fp8_line_ram_ctrl with a 4-pixel line.
module tb_fp8_line_ram_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fp8_line_ram_ctrl_if #(.AddrBits(2)) bus ();

  fp8_line_ram_ctrl #(
    .LINE_WIDTH (4),
    .ADDR_BITS  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] wd;
    logic       keep;
    logic [7:0] e_old;
    logic [7:0] e_new;
    logic [1:0] e_col;
    logic       e_wv;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pixel transaction; returns the strobed bytes, strobe count and cycles to pix_ready.
  task automatic run_pixel(input logic [7:0] wd, input logic keep,
                           output logic [7:0] b0, output logic [7:0] b1,
                           output int nstb, output int cyc);
    logic done;
    nstb = 0;
    cyc  = 0;
    b0   = 8'h00;
    b1   = 8'h00;
    done = 1'b0;
    bus.pix_valid = 1'b1;
    while (!done && cyc < 12) begin
      step();
      bus.wr_data = wd;
      cyc++;
      if (bus.rd_stb) begin
        if (nstb == 0) b0 = bus.rd_data;
        else           b1 = bus.rd_data;
        nstb++;
      end
      if (bus.pix_ready) done = 1'b1;
    end
    if (!done) chk("pix_ready_timeout", 32'(done), 32'd1);
    bus.pix_valid = keep;
  endtask

  logic [7:0] b0, b1;
  int nstb, cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sof       = 1'b0;
    bus.wr_src    = 1'b0;
    bus.pix_valid = 1'b0;
    bus.wr_data   = 8'h00;

    tbl[0]  = '{8'h11, 1'b0, 8'h00, 8'h00, 2'd1, 1'b0};
    tbl[1]  = '{8'h22, 1'b0, 8'h00, 8'h00, 2'd2, 1'b0};
    tbl[2]  = '{8'h33, 1'b0, 8'h00, 8'h00, 2'd3, 1'b0};
    tbl[3]  = '{8'h44, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0};
    tbl[4]  = '{8'h55, 1'b0, 8'h00, 8'h11, 2'd1, 1'b0};
    tbl[5]  = '{8'h66, 1'b0, 8'h00, 8'h22, 2'd2, 1'b0};
    tbl[6]  = '{8'h77, 1'b0, 8'h00, 8'h33, 2'd3, 1'b0};
    tbl[7]  = '{8'h88, 1'b0, 8'h00, 8'h44, 2'd0, 1'b1};
    tbl[8]  = '{8'h99, 1'b0, 8'h11, 8'h55, 2'd1, 1'b1};
    tbl[9]  = '{8'hAA, 1'b0, 8'h22, 8'h66, 2'd2, 1'b1};
    tbl[10] = '{8'hBB, 1'b0, 8'h33, 8'h77, 2'd3, 1'b1};
    tbl[11] = '{8'hCC, 1'b0, 8'h44, 8'h88, 2'd0, 1'b1};
    tbl[12] = '{8'hD1, 1'b1, 8'h55, 8'h99, 2'd0, 1'b0};
    tbl[13] = '{8'hD2, 1'b1, 8'h66, 8'hAA, 2'd0, 1'b0};
    tbl[14] = '{8'hD3, 1'b1, 8'h77, 8'hBB, 2'd0, 1'b0};
    tbl[15] = '{8'hD4, 1'b0, 8'h88, 8'hCC, 2'd0, 1'b1};
    tbl[16] = '{8'hF0, 1'b0, 8'h99, 8'hD1, 2'd1, 1'b1};
    tbl[17] = '{8'hF1, 1'b0, 8'hAA, 8'hD2, 2'd2, 1'b1};

    // Reset state
    #12;
    chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
    chk("rst_rd_stb", 32'(bus.rd_stb), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'h00);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_window_valid", 32'(bus.window_valid), 32'd0);
    chk("rst_col", 32'(bus.col), 32'd0);
    reset = 1'b1;
    step();

    // Reset asserted in the middle of RD_NEW
    bus.pix_valid = 1'b1;
    bus.wr_data   = 8'hAB;
    step();
    step();
    chk("midrd_rd_stb_before", 32'(bus.rd_stb), 32'd1);
    reset = 1'b0;
    bus.pix_valid = 1'b0;
    #1;
    chk("midrd_rd_stb", 32'(bus.rd_stb), 32'd0);
    chk("midrd_pix_ready", 32'(bus.pix_ready), 32'd0);
    chk("midrd_col", 32'(bus.col), 32'd0);
    chk("midrd_window_valid", 32'(bus.window_valid), 32'd0);
    chk("midrd_rd_data", 32'(bus.rd_data), 32'h00);
    step();
    reset = 1'b1;
    step();
    chk("midrd_idle_rd_stb", 32'(bus.rd_stb), 32'd0);

    // Start of frame in IDLE latches wr_src
    bus.sof    = 1'b1;
    bus.wr_src = 1'b1;
    step();
    bus.sof    = 1'b0;
    bus.wr_src = 1'b0;
    chk("sof_idle_sel", 32'(bus.sel), 32'd1);
    chk("sof_idle_col", 32'(bus.col), 32'd0);

    // Lines 1..3, continuous line 4, and the first two pixels of line 5
    for (int i = 0; i < 18; i++) begin
      run_pixel(tbl[i].wd, tbl[i].keep, b0, b1, nstb, cyc);
      chk($sformatf("v%0d_old", i), 32'(b0), 32'(tbl[i].e_old));
      chk($sformatf("v%0d_new", i), 32'(b1), 32'(tbl[i].e_new));
      chk($sformatf("v%0d_nstb", i), 32'(nstb), 32'd2);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'd3);
      if (!tbl[i].keep) begin
        step();
        chk($sformatf("v%0d_col", i), 32'(bus.col), 32'(tbl[i].e_col));
        chk($sformatf("v%0d_wv", i), 32'(bus.window_valid), 32'(tbl[i].e_wv));
        chk($sformatf("v%0d_ready_pulse", i), 32'(bus.pix_ready), 32'd0);
      end
    end

    // sof during RD_OLD of column 2: pixel completes, then frame state clears
    bus.pix_valid = 1'b1;
    bus.wr_data   = 8'hF2;
    step();
    bus.sof    = 1'b1;
    bus.wr_src = 1'b0;
    step();
    bus.sof = 1'b0;
    chk("sof_rdold_stb_old", 32'(bus.rd_stb), 32'd1);
    chk("sof_rdold_old", 32'(bus.rd_data), 32'hBB);
    step();
    chk("sof_rdold_ready", 32'(bus.pix_ready), 32'd1);
    chk("sof_rdold_new", 32'(bus.rd_data), 32'hD3);
    bus.pix_valid = 1'b0;
    step();
    chk("sof_rdold_col", 32'(bus.col), 32'd0);
    chk("sof_rdold_wv", 32'(bus.window_valid), 32'd0);
    chk("sof_rdold_sel", 32'(bus.sel), 32'd0);
    chk("sof_rdold_hold", 32'(bus.rd_data), 32'hD3);

    for (int i = 0; i < 3; i++) begin
      run_pixel(8'hE0 + 8'(i), 1'b0, b0, b1, nstb, cyc);
      chk($sformatf("post_sof%0d_old", i), 32'(b0), 32'h00);
      chk($sformatf("post_sof%0d_new", i), 32'(b1), 32'h00);
      step();
      chk($sformatf("post_sof%0d_col", i), 32'(bus.col), 32'(i + 1));
    end

    // sof in the wrap WR (column 3): wrap suppressed, sel takes wr_src
    bus.pix_valid = 1'b1;
    bus.wr_data   = 8'hE3;
    step();
    step();
    step();
    chk("sof_wrap_ready", 32'(bus.pix_ready), 32'd1);
    bus.sof       = 1'b1;
    bus.wr_src    = 1'b1;
    bus.pix_valid = 1'b0;
    step();
    bus.sof    = 1'b0;
    bus.wr_src = 1'b0;
    chk("sof_wrap_col", 32'(bus.col), 32'd0);
    chk("sof_wrap_wv", 32'(bus.window_valid), 32'd0);
    chk("sof_wrap_sel", 32'(bus.sel), 32'd1);
    run_pixel(8'h5A, 1'b0, b0, b1, nstb, cyc);
    chk("sof_wrap_next_old", 32'(b0), 32'h00);
    chk("sof_wrap_next_new", 32'(b1), 32'h00);
    step();
    chk("sof_wrap_next_col", 32'(bus.col), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
